// File: rtl/act_requant_packer.sv
// Requantizes LeakyReLU activations to int8 and packs LANES bytes per word into a valid/ready FIFO.
// Optional macro ACT_REQUANT_STATS_EN adds the saturating sat_count output.
module act_requant_packer #(
  parameter int ACC_W      = 32,
  parameter int MULT_W     = 16,
  parameter int SHIFT_W    = 5,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_in,
  input  logic signed [ACC_W-1:0] y_in,
  input  logic [MULT_W-1:0]       scale_mult,
  input  logic [SHIFT_W-1:0]      scale_shift,
  input  logic signed [7:0]       zero_point,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*LANES-1:0]      out_data,
  output logic [LANES-1:0]        out_byte_en,
  output logic                    overflow,
  output logic                    busy
`ifdef ACT_REQUANT_STATS_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int PW  = ACC_W + MULT_W + 1;
  localparam int DW  = 8 * LANES;
  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // S1: full-width signed product
  logic                 s1_v;
  logic signed [PW-1:0] s1_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_v <= done_in;
      if (done_in)
        s1_prod <= $signed({{(PW-ACC_W){y_in[ACC_W-1]}}, y_in}) *
                   $signed({{(PW-MULT_W){1'b0}}, scale_mult});
    end
  end

  // S2: rounding shift, zero point, clamp
  logic signed [PW-1:0] rnd_add;
  logic signed [PW-1:0] r_val;
  logic        [PW:0]   v_val;
  logic                 sat_hi;
  logic                 sat_lo;
  logic        [7:0]    byte_c;

  always_comb begin
    rnd_add = '0;
    if (scale_shift != '0)
      rnd_add = $signed({{(PW-1){1'b0}}, 1'b1} << (scale_shift - SHIFT_W'(1)));
    r_val  = (s1_prod + rnd_add) >>> scale_shift;
    v_val  = {r_val[PW-1], r_val} + {{(PW-7){zero_point[7]}}, zero_point};
    // In range iff the bits above bit 6 are a pure sign extension.
    sat_hi = !v_val[PW] && (|v_val[PW-1:7]);
    sat_lo =  v_val[PW] && !(&v_val[PW-1:7]);
    if (sat_hi)
      byte_c = 8'h7F;
    else if (sat_lo)
      byte_c = 8'h80;
    else
      byte_c = v_val[7:0];
  end

  logic       s2_v;
  logic [7:0] s2_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_byte <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v)
        s2_byte <= byte_c;
    end
  end

`ifdef ACT_REQUANT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (s1_v && (sat_hi || sat_lo) && (sat_count != '1))
      sat_count <= sat_count + 16'd1;
  end
`endif

  // Lane assembly, flush and FIFO push/pop control
  logic [LCW-1:0]   lane_cnt;
  logic [DW-1:0]    asm_q;
  logic             flush_pending;
  logic [DW-1:0]    word_c;
  logic [LANES-1:0] part_be;
  logic             last_lane;
  logic             flush_go;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             can_push;
  logic [DW-1:0]    push_data;
  logic [LANES-1:0] push_be;

  logic [DW-1:0]    mem    [FIFO_DEPTH];
  logic [LANES-1:0] be_mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    pop        = !fifo_empty && out_ready;
    can_push   = !fifo_full || pop;
    last_lane  = (lane_cnt == LCW'(LANES - 1));
    flush_go   = flush_pending && !s1_v && !s2_v;

    word_c = asm_q;
    word_c[8*lane_cnt +: 8] = s2_byte;
    part_be = '0;
    for (int unsigned i = 0; i < LANES; i++)
      part_be[i] = (LCW'(i) < lane_cnt);

    push_req  = 1'b0;
    push_data = word_c;
    push_be   = '1;
    // Lane write and flush cannot coincide: a flush only runs with S2 idle.
    if (s2_v) begin
      push_req = last_lane;
    end else if (flush_go && (lane_cnt != '0)) begin
      push_req  = 1'b1;
      push_data = asm_q;
      push_be   = part_be;
    end
    push = push_req && can_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt      <= '0;
      asm_q         <= '0;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (s2_v) begin
        if (last_lane) begin
          lane_cnt <= '0;
          asm_q    <= '0;
          if (!can_push)
            overflow <= 1'b1;
        end else begin
          lane_cnt <= lane_cnt + LCW'(1);
          asm_q    <= word_c;
        end
      end

      if (flush_go && ((lane_cnt == '0) || can_push)) begin
        flush_pending <= 1'b0;
        lane_cnt      <= '0;
        asm_q         <= '0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i]    <= '0;
        be_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr]    <= push_data;
        be_mem[wptr] <= push_be;
        wptr         <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  assign out_valid   = !fifo_empty;
  assign out_data    = mem[rptr];
  assign out_byte_en = be_mem[rptr];
  assign busy        = s1_v | s2_v | (lane_cnt != '0) | flush_pending | !fifo_empty;

endmodule

// File: tb/tb_act_requant_packer.sv
// Self-checking bench for act_requant_packer: vector table plus scoreboard of expected output words.
module tb_act_requant_packer;

  logic               clk = 1'b0;
  logic               rst;
  logic               done_in;
  logic signed [31:0] y_in;
  logic [15:0]        scale_mult;
  logic [4:0]         scale_shift;
  logic signed [7:0]  zero_point;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [3:0]         out_byte_en;
  logic               overflow;
  logic               busy;
`ifdef ACT_REQUANT_STATS_EN
  logic [15:0]        sat_count;
`endif

  act_requant_packer #(
    .ACC_W(32), .MULT_W(16), .SHIFT_W(5), .LANES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .y_in(y_in),
    .scale_mult(scale_mult), .scale_shift(scale_shift), .zero_point(zero_point),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_byte_en(out_byte_en), .overflow(overflow), .busy(busy)
`ifdef ACT_REQUANT_STATS_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [15:0]        mult;
    logic [4:0]         shift;
    logic signed [7:0]  zp;
    logic [3:0][31:0]   ys;
    logic [31:0]        exp_word;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_popped = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted head word against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_popped++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data", {32'h0, out_data}, {32'h0, e.data});
        check("word_be", {60'h0, out_byte_en}, {60'h0, e.be});
      end
    end
  end

  function automatic logic [7:0] model(input longint y, input longint m, input int sh, input longint zp);
    longint p, r, v;
    p = y * m;
    r = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
    v = r + zp;
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] y);
    done_in = 1'b1;
    y_in    = y;
    tick();
    done_in = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && busy; c++)
      tick();
    check("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  task automatic set_cfg(input logic [15:0] m, input logic [4:0] s, input logic [7:0] z);
    scale_mult  = m;
    scale_shift = s;
    zero_point  = z;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    int base;
    logic [31:0] w;
    logic [31:0] ys[4];

    tbl[0] = '{16'd1, 5'd0, 8'sd0,
               {32'hFFFFFF80, 32'd127, 32'hFFFFFFF6, 32'd5}, 32'h807FF605};
    tbl[1] = '{16'd3, 5'd2, 8'sd0,
               {32'd1, 32'd2, 32'd10, 32'hFFFFFFF6}, 32'h010208F9};
    tbl[2] = '{16'd1, 5'd0, 8'sd50,
               {32'hFFFFFFCE, 32'd100, 32'hFFFFFE70, 32'd300}, 32'h007F807F};
    tbl[3] = '{16'd1, 5'd1, 8'sd0,
               {32'd3, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF}, 32'h02FF0100};
    tbl[4] = '{16'hFFFF, 5'd31, -8'sd5,
               {32'd100000, 32'd0, 32'h80000000, 32'h7FFFFFFF}, 32'hFEFB807F};
    tbl[5] = '{16'd1, 5'd0, -8'sd128,
               {32'hFFFFFFFF, 32'd256, 32'd255, 32'd0}, 32'h807F7F80};

    rst = 1'b1; done_in = 1'b0; y_in = '0; flush = 1'b0; out_ready = 1'b1;
    set_cfg(16'd1, 5'd0, 8'd0);
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_ovf", {63'h0, overflow}, 64'h0);
    check("rst_data", {32'h0, out_data}, 64'h0);
    check("rst_be", {60'h0, out_byte_en}, 64'h0);

    // Table vectors, including output latency on the first one
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      set_cfg(tbl[i].mult, tbl[i].shift, tbl[i].zp);
      for (int l = 0; l < 4; l++) begin
        if (l == 3) exp_q.push_back('{tbl[i].exp_word, 4'hF});
        send(tbl[i].ys[l]);
      end
      if (i == 0) begin
        check("lat_edge1", {63'h0, out_valid}, 64'h0);
        tick();
        check("lat_edge2", {63'h0, out_valid}, 64'h0);
        tick();
        check("lat_edge3", {63'h0, out_valid}, 64'h1);
      end
`ifdef ACT_REQUANT_STATS_EN
      if (i == 2) begin
        wait_idle();
        check("sat_count", {48'h0, sat_count}, 64'd3);
      end
`endif
    end

    // Random words against the reference model
    for (int k = 0; k < 8; k++) begin
      wait_idle();
      set_cfg(16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      for (int l = 0; l < 4; l++) begin
        ys[l] = (k % 2 == 1) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
        w[8*l +: 8] = model(longint'($signed(ys[l])), longint'(scale_mult),
                            int'(scale_shift), longint'(zero_point));
      end
      exp_q.push_back('{w, 4'hF});
      for (int l = 0; l < 4; l++) send(ys[l]);
    end

    // Partial flush after three bytes, then an empty flush
    wait_idle();
    set_cfg(16'd1, 5'd0, 8'd0);
    exp_q.push_back('{32'h00030201, 4'h7});
    send(1); send(2); send(3);
    pulse_flush();
    wait_idle();
    check("flush_busy", {63'h0, busy}, 64'h0);
    base = n_popped;
    pulse_flush();
    repeat (10) tick();
    check("empty_flush_words", 64'(n_popped - base), 64'h0);
    check("empty_flush_busy", {63'h0, busy}, 64'h0);

    // Flush raised together with the last byte still picks it up
    exp_q.push_back('{32'h00000B0A, 4'h3});
    send(10);
    done_in = 1'b1; y_in = 11; flush = 1'b1;
    tick();
    done_in = 1'b0; flush = 1'b0;
    wait_idle();

    // Partial flush waits for room in a full FIFO instead of dropping
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3)
        exp_q.push_back('{{8'(i), 8'(i-1), 8'(i-2), 8'(i-3)}, 4'hF});
      send(i);
    end
    exp_q.push_back('{32'h00006564, 4'h3});
    send(100); send(101);
    pulse_flush();
    repeat (10) tick();
    check("full_flush_busy", {63'h0, busy}, 64'h1);
    check("full_flush_ovf", {63'h0, overflow}, 64'h0);
    base = n_popped;
    out_ready = 1'b1;
    wait_idle();
    check("full_flush_words", 64'(n_popped - base), 64'd5);

    // Overflow: five words into a stalled four-entry FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 3 && i < 16)
        exp_q.push_back('{{8'(i+20), 8'(i+19), 8'(i+18), 8'(i+17)}, 4'hF});
      send(i + 20);
    end
    repeat (5) tick();
    check("ovf_set", {63'h0, overflow}, 64'h1);
    check("ovf_lane_wrap_busy", {63'h0, busy}, 64'h1);
    base = n_popped;
    out_ready = 1'b1;
    wait_idle();
    check("ovf_words", 64'(n_popped - base), 64'd4);
    check("ovf_sticky", {63'h0, overflow}, 64'h1);

    // Reset with a partial word in flight
    send(7); send(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst2_valid", {63'h0, out_valid}, 64'h0);
    check("rst2_busy", {63'h0, busy}, 64'h0);
    check("rst2_ovf", {63'h0, overflow}, 64'h0);
    exp_q.push_back('{32'h04030201, 4'hF});
    send(1); send(2); send(3); send(4);
    wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/act_requant_packer.md
Name: act_requant_packer

Overview:
- Consumer end of the LeakyReLU result interface. Samples each 32-bit signed activation `y` on the `done` strobe.
- Requantizes it to int8 with a per-layer multiplier, rounding shift and zero point, then saturates.
- Packs four int8 results into 32-bit little-endian words and hands them to the output-buffer writer through a small valid/ready FIFO.
- Sits between leaky_relu and the DPU output SRAM writer.

Parameters:
- ACC_W, 32, width of incoming activation y_in (signed)
- MULT_W, 16, width of scale_mult (unsigned)
- SHIFT_W, 5, width of scale_shift
- LANES, 4, int8 results per output word (out_data width = 8*LANES)
- FIFO_DEPTH, 4, output word FIFO entries (power of 2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- done_in  in  1  one-cycle strobe from leaky_relu, y_in valid this cycle
- y_in  in  ACC_W  signed activation
- scale_mult  in  MULT_W  unsigned requant multiplier, static during a layer
- scale_shift  in  SHIFT_W  arithmetic right shift, 0..31
- zero_point  in  8  signed output zero point
- flush  in  1  one-cycle pulse: emit partial word at end of tensor
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  8*LANES  packed word, lane 0 = bits[7:0]
- out_byte_en  out  LANES  valid lanes of head word
- overflow  out  1  sticky: a completed word was dropped
- busy  out  1  any data in flight, pending flush, or FIFO non-empty

Behaviour:
- Reset: all state clears on any rising edge with rst=1. Outputs reset to 0: out_valid, out_data, out_byte_en, overflow, busy. lane_cnt=0, flush_pending=0, FIFO empty, pipeline valids 0.
- No back-pressure toward leaky_relu. done_in is always accepted.
- S1, registered on the edge after done_in: prod = y_in * $signed({1'b0,scale_mult}). Full width ACC_W+MULT_W+1, signed.
- S2, registered:
  - r = (shift==0) ? prod : (prod + (1<<(shift-1))) >>> shift. This is round-half-up toward +inf.
  - v = r + zero_point, sign-extended.
  - byte = clamp(v, -128, 127).
- Lane write: byte goes to lane lane_cnt of the assembly register. lane_cnt increments and wraps to 0 after LANES-1.
- Completed word: on the write of lane LANES-1 the word is pushed to the FIFO with byte_en all ones.
- Latency: done_in at edge N → S1 at N+1, S2 at N+2, byte in lane/FIFO push at N+3. out_valid rises after edge N+3 for the completing byte.
- FIFO rules:
  - out_valid = !empty. Pop on out_valid && out_ready. out_data/out_byte_en show the head combinationally from the FIFO registers.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full with no pop: the word is dropped, overflow is set sticky until rst, and lane_cnt still wraps.
- Flush:
  - The flush pulse sets flush_pending.
  - The flush executes on the first cycle where S1, S2 and the lane write are idle. Bytes entering the pipeline before that cycle are included.
  - If lane_cnt>0: push the partial word, with unused lanes = 0 and byte_en = (1<<lane_cnt)-1. Then set lane_cnt=0 and clear flush_pending.
  - If the FIFO is full without a pop, keep flush_pending and retry. Partial flushes never drop.
  - If lane_cnt==0: clear flush_pending, push nothing.
  - A flush pulse while flush_pending=1 is absorbed.
- busy = S1v | S2v | (lane_cnt!=0) | flush_pending | !empty.
- Inputs scale_mult, scale_shift and zero_point are sampled at S1/S2 respectively. Changing them with data in flight is unsupported.

Optional Feature:
- Macro ACT_REQUANT_STATS_EN.
- Defined: adds output port sat_count (16 bits). It increments on each S2 byte whose v lay outside [-128,127]. It saturates at 16'hFFFF and clears on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. mult=1, shift=0, zp=0; done_in with y=5,-10,127,-128 on consecutive cycles → one word out_data=32'h807FF605, byte_en=4'hF. out_valid rises 3 cycles after the 4th done_in.
2. mult=3, shift=2, zp=0; y=-10,10,2,1 → bytes F9,08,02,01, out_data=32'h010208F9 (checks round-half-up on negatives).
3. mult=1, shift=0, zp=50; y=300,-400,100,-50 → bytes 7F,80,7F,00, out_data=32'h007F807F. With ACT_REQUANT_STATS_EN, sat_count=3.
4. mult=1, shift=0, zp=0; y=1,2,3 then flush → out_data=32'h00030201, byte_en=4'h7, busy falls afterwards. A second flush with lane_cnt=0 → no output.
5. out_ready=0; 20 bytes fed (5 words) → 4 words held, overflow=1, fifth dropped. Then out_ready=1 → 4 words popped in order, overflow stays 1.
6. Feed 2 bytes, assert rst for 1 cycle → out_valid=0, busy=0, overflow=0. Next 4 bytes 1,2,3,4 → out_data=32'h04030201.
